// File: rtl/mibench_dot16_acc.sv
// Streaming signed 16-bit dot product with an external truncating multiplier.
// Operands are registered toward the multiplier and accumulated one cycle later.
module mibench_dot16_acc #(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 ap_idle,
  output logic                 ap_done,
  output logic                 ap_ready,
  input  logic [15:0]          in_a,
  input  logic [15:0]          in_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [15:0]          mul_din0,
  output logic [15:0]          mul_din1,
  input  logic [15:0]          mul_dout,
  output logic [ACC_WIDTH-1:0] result
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic                 op_vld_q, op_vld_d;
  logic [15:0]          din0_q, din0_d;
  logic [15:0]          din1_q, din1_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 xfer;

  // Product is already truncated to 16 bits; only sign-extend it.
  assign prod_ext = ACC_WIDTH'($signed(mul_dout));
  assign acc_sum  = op_vld_q ? acc_q + prod_ext : acc_q;

  assign mul_din0 = din0_q;
  assign mul_din1 = din1_q;
  assign result   = result_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    count_d  = count_q;
    op_vld_d = 1'b0;
    din0_d   = din0_q;
    din1_d   = din1_q;
    acc_d    = acc_sum;
    result_d = result_q;

    ap_idle  = (state_q == StIdle);
    ap_done  = (state_q == StDone);
    ap_ready = ap_done;
    in_ready = (state_q == StRun) && (count_q < len_q);
    xfer     = in_valid && in_ready;

    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          len_d   = len;
          count_d = '0;
          acc_d   = '0;
          if (len == '0) begin
            result_d = '0;
            state_d  = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (xfer) begin
          din0_d   = in_a;
          din1_d   = in_b;
          op_vld_d = 1'b1;
          count_d  = count_q + 1'b1;
          if (count_d == len_q) state_d = StDrain;
        end
      end
      StDrain: begin
        result_d = acc_sum;
        state_d  = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      count_q  <= '0;
      op_vld_q <= 1'b0;
      din0_q   <= '0;
      din1_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      count_q  <= count_d;
      op_vld_q <= op_vld_d;
      din0_q   <= din0_d;
      din1_q   <= din1_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mibench_dot16_acc.sv
// Directed bench for mibench_dot16_acc: a 32-bit and a 16-bit accumulator instance share
// stimulus; a transaction-level model drives expectations checked every cycle.
module tb_mibench_dot16_acc;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        ap_start;
  logic [15:0] len;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_valid;

  logic        idle32, done32, ready32, in_ready32;
  logic [15:0] din0_32, din1_32, dout32;
  logic [31:0] res32;
  logic        idle16, done16, ready16, in_ready16;
  logic [15:0] din0_16, din1_16, dout16;
  logic [15:0] res16;

  int checks = 0;
  int errors = 0;

  // Model expectations for the current cycle
  logic        active = 1'b0;
  logic        exp_idle, exp_done, exp_in_ready;
  logic [31:0] exp_sum;

  logic signed [15:0] qa[$];
  logic signed [15:0] qb[$];
  bit                 qv[$];
  int                 dc;

  // External 16s x 16s -> 16 truncating multipliers
  assign dout32 = 16'($signed(din0_32) * $signed(din1_32));
  assign dout16 = 16'($signed(din0_16) * $signed(din1_16));

  mibench_dot16_acc #(.ACC_WIDTH(32), .LEN_WIDTH(16)) dut32 (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .len      (len),
    .ap_idle  (idle32),
    .ap_done  (done32),
    .ap_ready (ready32),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_valid (in_valid),
    .in_ready (in_ready32),
    .mul_din0 (din0_32),
    .mul_din1 (din1_32),
    .mul_dout (dout32),
    .result   (res32)
  );

  mibench_dot16_acc #(.ACC_WIDTH(16), .LEN_WIDTH(16)) dut16 (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .len      (len),
    .ap_idle  (idle16),
    .ap_done  (done16),
    .ap_ready (ready16),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_valid (in_valid),
    .in_ready (in_ready16),
    .mul_din0 (din0_16),
    .mul_din1 (din1_16),
    .mul_dout (dout16),
    .result   (res16)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [31:0] prod(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    logic signed [31:0] p;
    logic signed [15:0] t;
    p = a * b;
    t = p[15:0];
    return 32'(t);
  endfunction

  always @(negedge ap_clk) begin
    if (ap_rst_n && active) begin
      check("idle32", {31'b0, idle32}, {31'b0, exp_idle});
      check("done32", {31'b0, done32}, {31'b0, exp_done});
      check("ready32", {31'b0, ready32}, {31'b0, exp_done});
      check("in_ready32", {31'b0, in_ready32}, {31'b0, exp_in_ready});
      check("result32", res32, exp_sum);
      check("done16", {31'b0, done16}, {31'b0, exp_done});
      check("in_ready16", {31'b0, in_ready16}, {31'b0, exp_in_ready});
      check("result16", {16'b0, res16}, {16'b0, exp_sum[15:0]});
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // One dot product; stimulus from qa/qb, in_valid pattern cycles through qv.
  task automatic run_dot(input int n, input bit start_in_run, output int done_cyc);
    int sent;
    int cyc;
    int vi;
    logic signed [31:0] sum;
    sent = 0;
    cyc  = 0;
    vi   = 0;
    sum  = 0;
    ap_start     = 1'b1;
    len          = 16'(n);
    in_valid     = 1'b0;
    exp_idle     = 1'b1;
    exp_done     = 1'b0;
    exp_in_ready = 1'b0;
    tick();
    cyc      = 1;
    ap_start = 1'b0;
    if (n > 0) begin
      while (sent < n && cyc < 1000) begin
        exp_idle     = 1'b0;
        exp_done     = 1'b0;
        exp_in_ready = 1'b1;
        ap_start     = start_in_run;
        in_valid     = qv[vi % qv.size()];
        vi++;
        in_a = qa[sent];
        in_b = qb[sent];
        if (in_valid) begin
          sum = sum + prod(qa[sent], qb[sent]);
          sent++;
        end
        tick();
        cyc++;
      end
      // Drain: stray valid data and start must be ignored
      exp_in_ready = 1'b0;
      ap_start     = start_in_run;
      in_valid     = 1'b1;
      in_a         = 16'h7fff;
      in_b         = 16'h7fff;
      tick();
      cyc++;
    end
    ap_start     = 1'b0;
    in_valid     = 1'b0;
    exp_idle     = 1'b0;
    exp_done     = 1'b1;
    exp_in_ready = 1'b0;
    exp_sum      = sum;
    done_cyc     = cyc;
    tick();
    exp_done = 1'b0;
    exp_idle = 1'b1;
  endtask

  initial begin
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    len      = '0;
    in_a     = '0;
    in_b     = '0;
    in_valid = 1'b0;
    #12;
    check("rst_idle", {31'b0, idle32}, 32'd1);
    check("rst_done", {31'b0, done32}, 32'd0);
    check("rst_ready", {31'b0, ready32}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready32}, 32'd0);
    check("rst_result", res32, 32'd0);
    check("rst_din", {din0_32, din1_32}, 32'd0);
    #10;
    ap_rst_n     = 1'b1;
    exp_idle     = 1'b1;
    exp_done     = 1'b0;
    exp_in_ready = 1'b0;
    exp_sum      = '0;
    active       = 1'b1;
    tick();

    qa = '{16'sd2, -16'sd4, 16'sd7};
    qb = '{16'sd3, 16'sd5, -16'sd1};
    qv = '{1'b1};
    run_dot(3, 1'b0, dc);
    check("basic_latency", 32'(dc), 32'd5);
    check("basic_lit", res32, 32'hFFFFFFEB);

    qa = '{16'sd300};
    qb = '{16'sd300};
    run_dot(1, 1'b0, dc);
    check("trunc_lit", res32, 32'd24464);

    qa = '{-16'sd32768};
    qb = '{-16'sd1};
    run_dot(1, 1'b0, dc);
    check("trunc_min_lit", res32, 32'hFFFF8000);

    run_dot(0, 1'b0, dc);
    check("zero_latency", 32'(dc), 32'd1);
    check("zero_lit", res32, 32'd0);

    qa = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
    qb = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
    qv = '{1'b1, 1'b0};
    run_dot(4, 1'b1, dc);
    check("bp_lit", res32, 32'd4);
    tick();

    qa = '{16'sd181, 16'sd181};
    qb = '{16'sd181, 16'sd181};
    qv = '{1'b1};
    run_dot(2, 1'b0, dc);
    check("wrap32_lit", res32, 32'h0000FFF2);
    check("wrap16_lit", {16'b0, res16}, 32'h0000FFF2);

    // Reset in the middle of a len=8 run after three transfers
    ap_start = 1'b1;
    len      = 16'd8;
    tick();
    ap_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_idle     = 1'b0;
      exp_in_ready = 1'b1;
      in_valid     = 1'b1;
      in_a         = 16'sd1;
      in_b         = 16'sd1;
      tick();
    end
    in_valid = 1'b0;
    active   = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    check("mid_rst_idle", {31'b0, idle32}, 32'd1);
    check("mid_rst_in_ready", {31'b0, in_ready32}, 32'd0);
    check("mid_rst_done", {31'b0, done32}, 32'd0);
    check("mid_rst_result", res32, 32'd0);
    check("mid_rst_result16", {16'b0, res16}, 32'd0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n     = 1'b1;
    exp_idle     = 1'b1;
    exp_done     = 1'b0;
    exp_in_ready = 1'b0;
    exp_sum      = '0;
    active       = 1'b1;
    repeat (5) tick();

    qa = '{16'sd3, 16'sd3};
    qb = '{16'sd3, 16'sd3};
    run_dot(2, 1'b0, dc);
    check("after_rst_lit", res32, 32'd18);
    repeat (2) tick();

    active = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mibench_dot16_acc.md
MIBENCH_DOT16_ACC -- requirements
Module: mibench_dot16_acc

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32: accumulator and result width in bits (at least 16).
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of the element-count input.
REQ-003 SHALL have port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ap_start, input, 1 bit: begin a dot product; sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_WIDTH bits: unsigned element count; latched on accepted ap_start.
REQ-007 SHALL have port ap_idle, output, 1 bit: high in IDLE.
REQ-008 SHALL have port ap_done, output, 1 bit: one-cycle pulse; result is final.
REQ-009 SHALL have port ap_ready, output, 1 bit: equal to ap_done.
REQ-010 SHALL have port in_a, input, 16 bits: signed operand A.
REQ-011 SHALL have port in_b, input, 16 bits: signed operand B.
REQ-012 SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-013 SHALL have port in_ready, output, 1 bit: block accepts the pair this cycle.
REQ-014 SHALL have port mul_din0, output, 16 bits: registered operand A to the external 16s x 16s -> 16 combinational multiplier.
REQ-015 SHALL have port mul_din1, output, 16 bits: registered operand B to the multiplier.
REQ-016 SHALL have port mul_dout, input, 16 bits: signed truncated product, valid in the same cycle as mul_din0/mul_din1.
REQ-017 SHALL have port result, output, ACC_WIDTH bits: signed dot-product result.

Function
REQ-018 SHALL implement the FSM IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE: ap_start=1 latches len, clears acc and the element count and op_vld; next state is DONE if len==0, else RUN.
REQ-020 RUN: in_ready=1 while count<len; a pair transfers on in_valid&in_ready.
REQ-021 Transfer: in_a/in_b SHALL register into mul_din0/mul_din1, op_vld is set for the next cycle, and count increments.
REQ-022 No transfer: op_vld=0; mul_din0/mul_din1 SHALL hold their values.
REQ-023 When op_vld=1, acc SHALL become acc + sign-extended mul_dout, one cycle after transfer.
REQ-024 Accumulation SHALL use modulo 2^ACC_WIDTH wrap, with no saturation.
REQ-025 When the final pair transfers (count becomes len), the next state SHALL be DRAIN and in_ready SHALL drop in the following cycle.
REQ-026 DRAIN: lasts one cycle and accumulates the last product.
REQ-027 DRAIN: the new acc value SHALL be copied into result, and the next state is DONE.
REQ-028 DONE: ap_done=ap_ready=1 for exactly one cycle, then return to IDLE.
REQ-029 result SHALL hold its value until the next accepted ap_start with len>0 completes DRAIN.
REQ-030 len==0 SHALL load result=0 at DONE entry.
REQ-031 Latency with in_valid held high: ap_start at cycle 0, transfers at cycles 1..N, DRAIN at N+1, ap_done at N+2.
REQ-032 len==0 latency: ap_done at cycle 1.
REQ-033 ap_start outside IDLE SHALL be ignored.
REQ-034 in_ready SHALL be 0 in IDLE, DRAIN and DONE.
REQ-035 in_valid with in_ready=0 SHALL have no effect.
REQ-036 Gaps in in_valid SHALL stall RUN indefinitely with no timeout.
REQ-037 ap_idle SHALL be 1 only in IDLE; it is 0 in the ap_done cycle.
REQ-038 The multiplier product SHALL be 16-bit truncated (low 16 bits, two's complement); the block SHALL NOT widen it.

Reset
REQ-039 ap_rst_n=0 SHALL immediately force state IDLE, independent of ap_clk.
REQ-040 During reset, acc, result, count, op_vld, mul_din0 and mul_din1 SHALL be 0.
REQ-041 During reset, ap_done=ap_ready=in_ready=0 and ap_idle=1.
REQ-042 Reset mid-operation SHALL abandon the run: no ap_done pulse and result=0.
REQ-043 Reset deassertion SHALL be synchronous to ap_clk; the first ap_start is sampled on the first rising edge after deassertion.

Verification
REQ-044 Basic run: len=3, pairs (2,3),(-4,5),(7,-1) streamed back-to-back -> ap_done at cycle 5, result=-21 (0xFFFFFFEB).
REQ-045 Truncation: len=1, pair (300,300) -> product 0x5F90, result=24464.
REQ-045a Truncation: len=1, pair (-32768,-1) -> result=-32768.
REQ-046 Zero length: len=0 -> ap_done at cycle 1, result=0, in_ready never asserted.
REQ-047 Backpressure: len=4, all pairs (1,1), in_valid toggling 1,0,1,0 -> exactly 4 transfers, result=4.
REQ-047a Backpressure: in_ready low after the 4th transfer; ap_start asserted during RUN is ignored.
REQ-048 Reset mid-run: len=8, ap_rst_n=0 after 3 transfers -> immediate IDLE, result=0, no ap_done.
REQ-048a Reset mid-run: a new run of len=2 with (3,3),(3,3) -> result=18.
REQ-049 Wrap: ACC_WIDTH=16, len=2, pairs (181,181) twice -> products 32761 each, result=-14 (0xFFF2).
